// File: rtl/issue_queue_mw_if.sv
// Port bundle for the multi-issue reservation station: dispatch slots, CDB
// wakeup, branch resolution and issue ports.
interface issue_queue_mw_if #(
   parameter int N       = 16,
   parameter int DISP_W  = 2,
   parameter int ISSUE_W = 2,
   parameter int NUM_CDB = 2,
   parameter int TAG_W   = 6,
   parameter int PAY_W   = 64,
   parameter int BM_W    = 4
);
   localparam int FC_W = $clog2(N + 1);

   // Handshake: a dispatch slot transfers on an edge where disp_valid[s] and
   // disp_ready are both high; an issue port transfers where iss_valid[k] is
   // high, which only happens while fu_ready[k] is high. Neither side waits.
   logic [DISP_W-1:0]                disp_valid;
   logic [DISP_W-1:0][TAG_W-1:0]     disp_t1;
   logic [DISP_W-1:0][TAG_W-1:0]     disp_t2;
   logic [DISP_W-1:0]                disp_r1;
   logic [DISP_W-1:0]                disp_r2;
   logic [DISP_W-1:0][TAG_W-1:0]     disp_dest;
   logic [DISP_W-1:0][BM_W-1:0]      disp_mask;
   logic [DISP_W-1:0][PAY_W-1:0]     disp_pay;
   logic                             disp_ready;

   logic [NUM_CDB-1:0]               cdb_valid;
   logic [NUM_CDB-1:0][TAG_W-1:0]    cdb_tag;

   logic                             br_valid;
   logic [BM_W-1:0]                  br_bit;
   logic                             br_mispredict;

   logic [ISSUE_W-1:0]               fu_ready;
   logic [ISSUE_W-1:0]               iss_valid;
   logic [ISSUE_W-1:0][TAG_W-1:0]    iss_t1;
   logic [ISSUE_W-1:0][TAG_W-1:0]    iss_t2;
   logic [ISSUE_W-1:0][TAG_W-1:0]    iss_dest;
   logic [ISSUE_W-1:0][BM_W-1:0]     iss_mask;
   logic [ISSUE_W-1:0][PAY_W-1:0]    iss_pay;

   logic [FC_W-1:0]                  free_count;

   modport master (
      output disp_valid, disp_t1, disp_t2, disp_r1, disp_r2, disp_dest,
             disp_mask, disp_pay, cdb_valid, cdb_tag, br_valid, br_bit,
             br_mispredict, fu_ready,
      input  disp_ready, iss_valid, iss_t1, iss_t2, iss_dest, iss_mask,
             iss_pay, free_count
   );

   modport slave (
      input  disp_valid, disp_t1, disp_t2, disp_r1, disp_r2, disp_dest,
             disp_mask, disp_pay, cdb_valid, cdb_tag, br_valid, br_bit,
             br_mispredict, fu_ready,
      output disp_ready, iss_valid, iss_t1, iss_t2, iss_dest, iss_mask,
             iss_pay, free_count
   );
endinterface

// File: rtl/issue_queue_mw.sv
// Unified N-entry reservation station: multi-slot dispatch, CDB wakeup,
// age-matrix oldest-ready select over ISSUE_W ports, branch squash/clear.
module issue_queue_mw #(
   parameter int N       = 16,
   parameter int DISP_W  = 2,
   parameter int ISSUE_W = 2,
   parameter int NUM_CDB = 2,
   parameter int TAG_W   = 6,
   parameter int PAY_W   = 64,
   parameter int BM_W    = 4
) (
   input  logic             clock,
   input  logic             reset,
   issue_queue_mw_if.slave  io
);
   localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
   localparam int SLOT_W = (DISP_W > 1) ? $clog2(DISP_W) : 1;
   localparam int FC_W   = $clog2(N + 1);

   logic [N-1:0]       valid_q, r1_q, r2_q;
   logic [TAG_W-1:0]   t1_q   [N];
   logic [TAG_W-1:0]   t2_q   [N];
   logic [TAG_W-1:0]   dest_q [N];
   logic [BM_W-1:0]    mask_q [N];
   logic [PAY_W-1:0]   pay_q  [N];
   logic [N-1:0]       old_q  [N];
   logic [FC_W-1:0]    free_q;

   logic [BM_W-1:0]    br_kill, br_clr;
   logic [N-1:0]       wake1, wake2, kill, eligible, issued, alloc_vec, valid_d;
   logic [DISP_W-1:0]  drdy1, drdy2, dkill, do_alloc;
   logic [IDX_W-1:0]   alloc_idx [DISP_W];
   logic [SLOT_W-1:0]  alloc_slot [N];
   logic [IDX_W-1:0]   sel_idx [ISSUE_W];
   logic [ISSUE_W-1:0] iss_go;
   logic [N-1:0]       old_d [N];
   logic [FC_W-1:0]    free_d;
   logic               disp_ready;

   assign br_kill    = (io.br_valid && io.br_mispredict)  ? io.br_bit : '0;
   assign br_clr     = (io.br_valid && !io.br_mispredict) ? io.br_bit : '0;
   assign disp_ready = (free_q >= FC_W'(DISP_W));
   assign io.disp_ready = disp_ready;
   assign io.free_count = free_q;

   // Tag 0 is the zero register and never waits.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         wake1[i] = (t1_q[i] == '0);
         wake2[i] = (t2_q[i] == '0);
         for (int c = 0; c < NUM_CDB; c++) begin
            if (io.cdb_valid[c] && io.cdb_tag[c] == t1_q[i]) wake1[i] = 1'b1;
            if (io.cdb_valid[c] && io.cdb_tag[c] == t2_q[i]) wake2[i] = 1'b1;
         end
         kill[i] = |(mask_q[i] & br_kill);
      end
      for (int s = 0; s < DISP_W; s++) begin
         drdy1[s] = io.disp_r1[s] || (io.disp_t1[s] == '0);
         drdy2[s] = io.disp_r2[s] || (io.disp_t2[s] == '0);
         for (int c = 0; c < NUM_CDB; c++) begin
            if (io.cdb_valid[c] && io.cdb_tag[c] == io.disp_t1[s]) drdy1[s] = 1'b1;
            if (io.cdb_valid[c] && io.cdb_tag[c] == io.disp_t2[s]) drdy2[s] = 1'b1;
         end
         dkill[s] = |(io.disp_mask[s] & br_kill);
      end
   end

   assign eligible = valid_q & r1_q & r2_q & ~kill;

   // A port that cannot accept leaves its candidate in the pool for the next port.
   always_comb begin : select
      logic [N-1:0]     pool;
      logic             found;
      logic             is_old;
      logic [IDX_W-1:0] cand;
      pool   = eligible;
      issued = '0;
      for (int k = 0; k < ISSUE_W; k++) begin
         found = 1'b0;
         cand  = '0;
         for (int i = 0; i < N; i++) begin
            is_old = pool[i];
            for (int j = 0; j < N; j++) begin
               if (pool[j] && old_q[j][i]) is_old = 1'b0;
            end
            if (is_old && !found) begin
               found = 1'b1;
               cand  = IDX_W'(i);
            end
         end
         sel_idx[k] = cand;
         iss_go[k]  = found && io.fu_ready[k] && reset;
         if (iss_go[k]) begin
            pool[cand]   = 1'b0;
            issued[cand] = 1'b1;
         end
      end
   end

   always_comb begin
      for (int k = 0; k < ISSUE_W; k++) begin
         io.iss_valid[k] = iss_go[k];
         io.iss_t1[k]    = t1_q[sel_idx[k]];
         io.iss_t2[k]    = t2_q[sel_idx[k]];
         io.iss_dest[k]  = dest_q[sel_idx[k]];
         io.iss_mask[k]  = mask_q[sel_idx[k]] & ~br_clr;
         io.iss_pay[k]   = pay_q[sel_idx[k]];
      end
   end

   // Slot s always maps to the s-th lowest free entry, whether or not it is used.
   always_comb begin : alloc
      int cnt;
      cnt       = 0;
      alloc_vec = '0;
      for (int i = 0; i < N; i++) alloc_slot[i] = '0;
      for (int s = 0; s < DISP_W; s++) alloc_idx[s] = '0;
      for (int i = 0; i < N; i++) begin
         if (!valid_q[i]) begin
            for (int s = 0; s < DISP_W; s++) begin
               if (cnt == s) alloc_idx[s] = IDX_W'(i);
            end
            cnt = cnt + 1;
         end
      end
      for (int s = 0; s < DISP_W; s++) begin
         do_alloc[s] = disp_ready && io.disp_valid[s] && !dkill[s];
         if (do_alloc[s]) begin
            alloc_vec[alloc_idx[s]]  = 1'b1;
            alloc_slot[alloc_idx[s]] = SLOT_W'(s);
         end
      end
   end

   // New entries are younger than every resident entry and ordered by slot.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         valid_d[i] = alloc_vec[i] || (valid_q[i] && !issued[i] && !kill[i]);
         for (int j = 0; j < N; j++) begin
            old_d[i][j] = old_q[i][j];
            if (alloc_vec[j]) begin
               if (alloc_vec[i]) old_d[i][j] = (alloc_slot[i] < alloc_slot[j]);
               else              old_d[i][j] = valid_q[i];
            end else if (alloc_vec[i]) begin
               old_d[i][j] = 1'b0;
            end
         end
      end
      free_d = FC_W'(N);
      for (int i = 0; i < N; i++) begin
         if (valid_d[i]) free_d = free_d - 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         valid_q <= '0;
         r1_q    <= '0;
         r2_q    <= '0;
         free_q  <= FC_W'(N);
         for (int i = 0; i < N; i++) old_q[i] <= '0;
      end else begin
         valid_q <= valid_d;
         free_q  <= free_d;
         for (int i = 0; i < N; i++) begin
            old_q[i] <= old_d[i];
            if (alloc_vec[i]) begin
               t1_q[i]   <= io.disp_t1[alloc_slot[i]];
               t2_q[i]   <= io.disp_t2[alloc_slot[i]];
               r1_q[i]   <= drdy1[alloc_slot[i]];
               r2_q[i]   <= drdy2[alloc_slot[i]];
               dest_q[i] <= io.disp_dest[alloc_slot[i]];
               mask_q[i] <= io.disp_mask[alloc_slot[i]] & ~br_clr;
               pay_q[i]  <= io.disp_pay[alloc_slot[i]];
            end else begin
               r1_q[i]   <= r1_q[i] | wake1[i];
               r2_q[i]   <= r2_q[i] | wake2[i];
               mask_q[i] <= mask_q[i] & ~br_clr;
            end
         end
      end
   end
endmodule

// File: doc/issue_queue_mw.md
# issue_queue_mw

Parametrised multi-issue successor to the single-port issue stage: an N-entry unified reservation station accepting up to DISP_W dispatches and issuing up to ISSUE_W operations per cycle. Sits between dispatch/rename and the register-read/execute stage. It wakes operands from NUM_CDB broadcast buses, selects oldest-ready entries through an age matrix, and squashes or clears entries on branch resolution. Register-file read is outside this block; issued tags feed the regfile read ports directly.

## Interface
- N, 16, number of RS entries (power of 2 not required, ≥ DISP_W + ISSUE_W)
- DISP_W, 2, dispatch slots per cycle
- ISSUE_W, 2, issue ports per cycle
- NUM_CDB, 2, CDB wakeup buses
- TAG_W, 6, physical register tag width (tag 0 = zero register)
- PAY_W, 64, opaque payload width (opcode, FU select, imm, ROB/SQ idx)
- BM_W, 4, branch-mask width
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- disp_valid  in  DISP_W  per-slot dispatch request; slot 0 is program-older
- disp_t1, disp_t2  in  DISP_W×TAG_W  source tags
- disp_r1, disp_r2  in  DISP_W  source already ready at rename
- disp_dest  in  DISP_W×TAG_W  destination tag (passed through)
- disp_mask  in  DISP_W×BM_W  branch dependency mask
- disp_pay  in  DISP_W×PAY_W  payload
- disp_ready  out  1  all DISP_W slots may dispatch this cycle
- cdb_valid  in  NUM_CDB; cdb_tag  in  NUM_CDB×TAG_W
- br_valid  in  1; br_bit  in  BM_W (one-hot); br_mispredict  in  1
- fu_ready  in  ISSUE_W  port k may accept an op this cycle
- iss_valid  out  ISSUE_W; iss_t1, iss_t2, iss_dest  out  ISSUE_W×TAG_W; iss_mask  out  ISSUE_W×BM_W; iss_pay  out  ISSUE_W×PAY_W
- free_count  out  $clog2(N+1)  registered free-entry count

## Operation
- Entry state: valid, t1, t2, r1, r2, dest, mask, pay; age matrix old[i][j]=1 ⇔ entry i older than j.
- Dispatch (disp_ready & disp_valid[s]): slot s takes the s-th lowest-index free entry; its age row set older-than none, all existing valid entries marked older; slot s older than slot s+1. disp_valid while !disp_ready is ignored (no entry written).
- disp_ready = free_count ≥ DISP_W.
- Wakeup: r1/r2 set when cdb_valid[c] & cdb_tag[c]==tag for any c; tag 0 always ready. Applies to stored entries and to same-cycle dispatch operands.
- Select: eligible = valid & r1 & r2. Port 0 gets oldest eligible; port k gets oldest eligible not chosen by ports <k. Port k with fu_ready[k]=0 issues nothing, and its candidate passes to port k+1. iss_valid[k] only with fu_ready[k]=1.
- Issued entries freed at the clock edge; outputs driven from registered entry state (combinational select).
- Branch resolve, br_valid: mispredict → every entry (including same-cycle dispatch and same-cycle issue candidates) with mask&br_bit≠0 invalidated, and iss_valid suppressed for such entries; correct → br_bit cleared in all masks, including incoming dispatch and iss_mask outputs.
- free_count next = free_count − dispatched + issued + squashed.

## Timing
- Reset (reset=0 at edge): all valid=0, age matrix 0, free_count=N, disp_ready=1, iss_valid=0.
- Dispatch at edge t → eligible to issue in cycle t+1 (zero cycles waiting when both operands ready).
- CDB at cycle t → entry issuable in cycle t+1; no same-cycle wakeup-to-issue.
- Freed slot (issue/squash) usable by dispatch in cycle t+1 (free_count registered).
- Full: free_count<DISP_W → disp_ready=0 even if some slots free.
- Simultaneous dispatch + issue + squash + CDB in one cycle: all apply; squash wins over issue and dispatch.
- reset mid-operation discards all entries at that edge; inputs ignored that cycle.

## Test plan
- Reset, dispatch 2 ready ops (t1=0,t2=0), fu_ready=11 → both issue next cycle, older on port 0; free_count 16→14→16.
- Dispatch op waiting on tag 5; cdb_valid=01, cdb_tag=5 at cycle 3 → iss_valid in cycle 4, not 3.
- Fill 16 entries, none ready → disp_ready=0 at free_count=0 and 1; dispatch attempts ignored; one CDB wake + issue → still 0 until free_count≥2.
- Three ready entries ages A<B<C, fu_ready=01 → port 0 issues A; fu_ready=10 → port 1 issues B next.
- br_valid, br_mispredict, br_bit=0010 with entries masked 0010/0011/0100 → first two gone next cycle, free_count +2; correct predict instead → masks become 0000/0001/0100.
- Pull reset=0 with 8 entries pending → all iss_valid=0, free_count=16 next cycle.
